// File: rtl/score_display.sv
// Score overlay: sequential double-dabble binary->BCD conversion plus a
// two-stage pixel pipeline that addresses the digit glyph ROM and emits a lit bit.
module score_display #(
  parameter int X_POS         = 16,
  parameter int Y_POS         = 8,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [13:0] score,
  input  logic        score_valid,
  output logic        busy,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic        score_pixel_on
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_SHIFT  = 2'd1;
  localparam logic [1:0]  S_COMMIT = 2'd2;
  localparam logic [13:0] MAX_SCORE = 14'd9999;
  localparam logic [3:0]  LAST_ITER = 4'd13;

  localparam logic [10:0] X_LO = 11'(X_POS);
  localparam logic [10:0] X_HI = 11'(X_POS + 32);
  localparam logic [10:0] Y_LO = 11'(Y_POS);
  localparam logic [10:0] Y_HI = 11'(Y_POS + 16);
  localparam logic [4:0]  X_LSB = 5'(X_POS);
  localparam logic [3:0]  Y_LSB = 4'(Y_POS);

  function automatic logic [13:0] clamp(input logic [13:0] v);
    return (v > MAX_SCORE) ? MAX_SCORE : v;
  endfunction

  // ---------------- conversion FSM ----------------
  logic [1:0]  state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d, bcd_adj;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] disp_q, disp_d;
  logic        pend_q, pend_d;
  logic [13:0] pend_val_q, pend_val_d;

  always_comb begin
    for (int i = 0; i < 4; i++)
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    case (state_q)
      S_IDLE: begin
        // A fresh request is newer than anything still pending.
        if (score_valid) begin
          bin_d   = clamp(score);
          bcd_d   = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = S_SHIFT;
        end else if (pend_q) begin
          bin_d   = pend_val_q;
          bcd_d   = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == LAST_ITER) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        disp_d = bcd_q;
        if (pend_q) begin
          bin_d   = pend_val_q;
          bcd_d   = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Requests arriving mid-conversion (including on COMMIT) queue up; latest wins.
    if (score_valid && (state_q != S_IDLE)) begin
      pend_d     = 1'b1;
      pend_val_d = clamp(score);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
    end
  end

  assign busy = (state_q != S_IDLE);

  // ---------------- pixel pipeline ----------------
  logic [3:0][3:0] dig;
  logic [3:0]      zero_run, blank_vec;
  logic            in_box;
  logic [4:0]      rel_x;
  logic [3:0]      rel_y;
  logic [1:0]      idx;
  logic [7:0]      addr_d;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dig
      assign dig[g] = disp_q[15-4*g -: 4];
      if (g == 0) begin : g_first
        assign zero_run[g] = (dig[g] == 4'd0);
      end else begin : g_rest
        assign zero_run[g] = zero_run[g-1] && (dig[g] == 4'd0);
      end
      assign blank_vec[g] = BLANK_LEADING && (g < 3) && zero_run[g];
    end
  endgenerate

  // Only the low bits of the box-relative offsets are ever needed.
  assign rel_x  = DrawX[4:0] - X_LSB;
  assign rel_y  = DrawY[3:0] - Y_LSB;
  assign idx    = rel_x[4:3];
  assign in_box = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                  ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);
  assign addr_d = in_box ? {dig[idx], rel_y} : {dig[0], 4'h0};

  logic [7:0] rom_addr_q;
  logic       in_box_d1, blank_d1, pix_q;
  logic [2:0] col_d1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr_q <= '0;
      in_box_d1  <= 1'b0;
      blank_d1   <= 1'b0;
      col_d1     <= '0;
      pix_q      <= 1'b0;
    end else begin
      rom_addr_q <= addr_d;
      in_box_d1  <= in_box;
      blank_d1   <= blank_vec[idx];
      col_d1     <= rel_x[2:0];
      pix_q      <= in_box_d1 & ~blank_d1 & rom_data[3'd7 - col_d1];
    end
  end

  assign rom_addr       = rom_addr_q;
  assign score_pixel_on = pix_q;

endmodule
